wb_frame_reader: RTL and testbench

Wishbone master that sits directly upstream of the wishbone BlockRAM slave and drains it toward the display path. On a `start` pulse it reads `nb_words` consecutive 32-bit words from `base_adr` using incrementing-address bursts. It buffers the words in an internal show-ahead FIFO and presents them on a valid/ready stream. Bursts are only launched when the FIFO has room for the whole burst, so the slave never sees a stalled beat caused by the consumer.

---
 rtl/wb_frame_reader.sv | 196 +++++++++++++++++++
 tb/tb_wb_frame_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_frame_reader.sv
// wb_frame_reader: Wishbone burst reader that drains a BlockRAM slave into a
// show-ahead FIFO and presents the words on a valid/ready pixel stream.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                one-cycle request (ignored while busy)
//   base_adr, nb_words   first byte address and number of 32-bit words
//   busy, done           transfer in progress / one-cycle completion pulse
//   wb_*                 Wishbone master (read-only, linear incrementing bursts)
//   pix_data, pix_valid  FIFO head word / FIFO not empty
//   pix_ready            consumer accepts the head word
module wb_frame_reader #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] nb_words,
  output logic        busy,
  output logic        done,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic [31:0] wb_dat_sm,
  input  logic        wb_ack,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BURST_LEN + 1);

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    BURST      = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     adr_q, adr_d;
  logic [15:0]     remaining_q, remaining_d;
  logic [BW-1:0]   beats_left_q, beats_left_d;
  logic [2:0]      cti_q, cti_d;
  logic            cyc_q, cyc_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic            push_c;
  logic            pop_c;
  logic [CW-1:0]   free_c;
  logic [CW-1:0]   len_c;

  // FIFO handshake and space accounting; free space already credits a pop
  // happening this cycle.
  assign pix_valid = (count_q != '0);
  assign pix_data  = mem_q[rd_ptr_q];
  assign pop_c     = pix_valid && pix_ready;
  assign push_c    = (state_q == BURST) && wb_ack;
  assign free_c    = CW'(FIFO_DEPTH) - count_q + CW'(pop_c);
  assign len_c     = (remaining_q < 16'(BURST_LEN)) ? CW'(remaining_q) : CW'(BURST_LEN);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    remaining_d  = remaining_q;
    beats_left_d = beats_left_q;
    cti_d        = cti_q;
    cyc_d        = cyc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          adr_d       = base_adr & 32'hFFFF_FFFC;
          remaining_d = nb_words;
          state_d     = (nb_words == 16'd0) ? DONE : WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        // Launch only when the whole burst fits, so the slave is never stalled.
        if (free_c >= len_c) begin
          state_d      = BURST;
          cyc_d        = 1'b1;
          beats_left_d = BW'(len_c);
          cti_d        = (len_c == CW'(1)) ? CTI_CLASSIC : CTI_INCR;
        end
      end
      BURST: begin
        if (wb_ack) begin
          adr_d        = adr_q + 32'd4;
          remaining_d  = remaining_q - 16'd1;
          beats_left_d = beats_left_q - BW'(1);
          if (beats_left_q == BW'(1)) begin
            cyc_d   = 1'b0;
            cti_d   = CTI_CLASSIC;
            state_d = (remaining_q == 16'd1) ? DONE : WAIT_SPACE;
          end else if (beats_left_q == BW'(2)) begin
            cti_d = CTI_EOB;
          end else begin
            cti_d = CTI_INCR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      adr_q        <= '0;
      remaining_q  <= '0;
      beats_left_q <= '0;
      cti_q        <= CTI_CLASSIC;
      cyc_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      remaining_q  <= remaining_d;
      beats_left_q <= beats_left_d;
      cti_q        <= cti_d;
      cyc_q        <= cyc_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  // Show-ahead FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= wb_dat_sm;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_c && !pop_c) begin
        count_q <= count_q + CW'(1);
      end else if (!push_c && pop_c) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Space check before each burst makes a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_c && (count_q == CW'(FIFO_DEPTH))));

  assign busy   = busy_q;
  assign done   = done_q;
  assign wb_cyc = cyc_q;
  assign wb_stb = cyc_q;
  assign wb_we  = 1'b0;
  assign wb_sel = 4'hF;
  assign wb_adr = adr_q;
  assign wb_cti = cti_q;
  assign wb_bte = 2'b00;

endmodule

// File: tb/tb_wb_frame_reader.sv
// Directed testbench for wb_frame_reader with a Wishbone slave model and a
// stream monitor; expected values are hand-computed per scenario.
module tb_wb_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] nb_words;
  logic        busy;
  logic        done;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] wb_dat_sm;
  logic        wb_ack;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  int n_cmp;
  int n_bad;

  // Slave/monitor state
  logic [31:0] beat_adr[$];
  logic [2:0]  beat_cti[$];
  logic [31:0] rx[$];
  int          done_cnt  = 0;
  int          burst_cnt = 0;
  int          stb_bad   = 0;
  int          unstable  = 0;
  int          wcnt      = 0;
  int          wait_n    = 0;
  logic        cyc_prev  = 1'b0;
  logic        prev_wait = 1'b0;
  logic [31:0] hold_adr  = '0;
  logic [2:0]  hold_cti  = '0;
  logic [31:0] dat_base  = '0;

  wb_frame_reader #(.FIFO_DEPTH(16), .BURST_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .nb_words(nb_words),
    .busy(busy), .done(done), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_cti(wb_cti), .wb_bte(wb_bte),
    .wb_dat_sm(wb_dat_sm), .wb_ack(wb_ack), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  // Slave model and monitor, evaluated mid-cycle; ack/data driven here are
  // consumed at the following rising edge. Slave data = dat_base ^ address.
  always @(negedge clk) begin
    if (!rst_n) begin
      wb_ack    = 1'b0;
      wcnt      = 0;
      cyc_prev  = 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (pix_valid && pix_ready) rx.push_back(pix_data);
      if (done) done_cnt++;
      if (wb_cyc && !cyc_prev) burst_cnt++;
      if (wb_cyc !== wb_stb) stb_bad++;
      if (wb_cyc && prev_wait && (wb_adr !== hold_adr || wb_cti !== hold_cti || wb_stb !== 1'b1))
        unstable++;
      cyc_prev = wb_cyc;
      hold_adr = wb_adr;
      hold_cti = wb_cti;
      if (wb_cyc) begin
        if (wcnt == wait_n) begin
          wb_ack    = 1'b1;
          wb_dat_sm = dat_base ^ wb_adr;
          beat_adr.push_back(wb_adr);
          beat_cti.push_back(wb_cti);
          wcnt      = 0;
          prev_wait = 1'b0;
        end else begin
          wb_ack    = 1'b0;
          wcnt++;
          prev_wait = 1'b1;
        end
      end else begin
        wb_ack    = 1'b0;
        wcnt      = 0;
        prev_wait = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    beat_adr.delete();
    beat_cti.delete();
    rx.delete();
    done_cnt  = 0;
    burst_cnt = 0;
    stb_bad   = 0;
    unstable  = 0;
  endtask

  // Present start for exactly one rising edge; returns 1 time unit after it.
  task automatic kick(input logic [31:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_adr = a; nb_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (!busy) break;
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_timeout: busy got %b want 0", name, busy); end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (pix_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
    n_cmp++; if (pix_data !== 32'h0)  begin n_bad++; $display("FAIL reset_pix_data: got %h want 0", pix_data); end
    n_cmp++; if (wb_cyc !== 1'b0)     begin n_bad++; $display("FAIL reset_cyc: got %b want 0", wb_cyc); end
    n_cmp++; if (wb_stb !== 1'b0)     begin n_bad++; $display("FAIL reset_stb: got %b want 0", wb_stb); end
    n_cmp++; if (wb_adr !== 32'h0)    begin n_bad++; $display("FAIL reset_adr: got %h want 0", wb_adr); end
    n_cmp++; if (wb_cti !== 3'b000)   begin n_bad++; $display("FAIL reset_cti: got %b want 000", wb_cti); end
    n_cmp++; if (wb_we !== 1'b0)      begin n_bad++; $display("FAIL const_we: got %b want 0", wb_we); end
    n_cmp++; if (wb_sel !== 4'hF)     begin n_bad++; $display("FAIL const_sel: got %h want f", wb_sel); end
    n_cmp++; if (wb_bte !== 2'b00)    begin n_bad++; $display("FAIL const_bte: got %b want 00", wb_bte); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    clear_mon();
    wait_n = 0; dat_base = 32'hCAFE_0101; pix_ready = 1'b1;
    kick(32'h100, 16'd1);
    n_cmp++; if (busy !== 1'b1)   begin n_bad++; $display("FAIL single_busy_n: got %b want 1", busy); end
    n_cmp++; if (wb_cyc !== 1'b0) begin n_bad++; $display("FAIL single_cyc_n: got %b want 0", wb_cyc); end
    @(posedge clk); #1;
    n_cmp++; if (wb_cyc !== 1'b1)     begin n_bad++; $display("FAIL single_cyc_n1: got %b want 1", wb_cyc); end
    n_cmp++; if (wb_stb !== 1'b1)     begin n_bad++; $display("FAIL single_stb_n1: got %b want 1", wb_stb); end
    n_cmp++; if (wb_adr !== 32'h100)  begin n_bad++; $display("FAIL single_adr: got %h want 100", wb_adr); end
    n_cmp++; if (wb_cti !== 3'b000)   begin n_bad++; $display("FAIL single_cti: got %b want 000", wb_cti); end
    @(posedge clk); #1;
    n_cmp++; if (wb_cyc !== 1'b0)           begin n_bad++; $display("FAIL single_cyc_drop: got %b want 0", wb_cyc); end
    n_cmp++; if (done !== 1'b1)             begin n_bad++; $display("FAIL single_done: got %b want 1", done); end
    n_cmp++; if (pix_valid !== 1'b1)        begin n_bad++; $display("FAIL single_valid: got %b want 1", pix_valid); end
    n_cmp++; if (pix_data !== 32'hCAFE0001) begin n_bad++; $display("FAIL single_data: got %h want cafe0001", pix_data); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL single_done_off: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL single_busy_off: got %b want 0", busy); end
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_off: got %b want 0", pix_valid); end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (beat_adr.size() !== 1) begin n_bad++; $display("FAIL single_beats: got %0d want 1", beat_adr.size()); end
    n_cmp++; if (rx.size() !== 1)       begin n_bad++; $display("FAIL single_rx_count: got %0d want 1", rx.size()); end
    n_cmp++; if (done_cnt !== 1)        begin n_bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_multi_burst();
    logic [2:0] exp_cti;
    clear_mon();
    wait_n = 0; dat_base = 32'h5A00_0000; pix_ready = 1'b1;
    kick(32'h0, 16'd20);
    wait_idle(300, "multi");
    n_cmp++; if (burst_cnt !== 3)        begin n_bad++; $display("FAIL multi_bursts: got %0d want 3", burst_cnt); end
    n_cmp++; if (beat_adr.size() !== 20) begin n_bad++; $display("FAIL multi_beats: got %0d want 20", beat_adr.size()); end
    n_cmp++; if (rx.size() !== 20)       begin n_bad++; $display("FAIL multi_rx_count: got %0d want 20", rx.size()); end
    n_cmp++; if (done_cnt !== 1)         begin n_bad++; $display("FAIL multi_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (stb_bad !== 0)          begin n_bad++; $display("FAIL multi_stb_eq_cyc: got %0d want 0", stb_bad); end
    for (int i = 0; i < 20; i++) begin
      exp_cti = (i == 7 || i == 15 || i == 19) ? 3'b111 : 3'b010;
      n_cmp++; if (beat_adr[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL multi_adr[%0d]: got %h want %h", i, beat_adr[i], 32'(4 * i)); end
      n_cmp++; if (beat_cti[i] !== exp_cti)    begin n_bad++; $display("FAIL multi_cti[%0d]: got %b want %b", i, beat_cti[i], exp_cti); end
      n_cmp++; if (rx[i] !== (32'h5A00_0000 + 32'(4 * i))) begin n_bad++; $display("FAIL multi_data[%0d]: got %h want %h", i, rx[i], 32'h5A00_0000 + 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    clear_mon();
    wait_n = 0; dat_base = 32'h7700_0000; pix_ready = 1'b0;
    kick(32'h1000, 16'd40);
    repeat (60) @(posedge clk); #1;
    n_cmp++; if (beat_adr.size() !== 16) begin n_bad++; $display("FAIL bp_stalled_beats: got %0d want 16", beat_adr.size()); end
    n_cmp++; if (wb_cyc !== 1'b0)        begin n_bad++; $display("FAIL bp_cyc_idle: got %b want 0", wb_cyc); end
    n_cmp++; if (busy !== 1'b1)          begin n_bad++; $display("FAIL bp_busy: got %b want 1", busy); end
    n_cmp++; if (pix_valid !== 1'b1)     begin n_bad++; $display("FAIL bp_valid: got %b want 1", pix_valid); end
    n_cmp++; if (pix_data !== 32'h7700_1000) begin n_bad++; $display("FAIL bp_head: got %h want 77001000", pix_data); end
    pix_ready = 1'b1;
    wait_idle(500, "bp");
    n_cmp++; if (beat_adr.size() !== 40) begin n_bad++; $display("FAIL bp_beats: got %0d want 40", beat_adr.size()); end
    n_cmp++; if (rx.size() !== 40)       begin n_bad++; $display("FAIL bp_rx_count: got %0d want 40", rx.size()); end
    n_cmp++; if (done_cnt !== 1)         begin n_bad++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    for (int i = 0; i < 40; i++) begin
      n_cmp++; if (rx[i] !== (32'h7700_1000 + 32'(4 * i))) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, rx[i], 32'h7700_1000 + 32'(4 * i)); end
    end
  endtask

  task automatic test_wait_states();
    logic [2:0] exp_cti;
    clear_mon();
    wait_n = 2; dat_base = 32'h1100_0000; pix_ready = 1'b1;
    kick(32'h200, 16'd5);
    wait_idle(300, "ws");
    n_cmp++; if (unstable !== 0)        begin n_bad++; $display("FAIL ws_stable: got %0d changes want 0", unstable); end
    n_cmp++; if (burst_cnt !== 1)       begin n_bad++; $display("FAIL ws_bursts: got %0d want 1", burst_cnt); end
    n_cmp++; if (beat_adr.size() !== 5) begin n_bad++; $display("FAIL ws_beats: got %0d want 5", beat_adr.size()); end
    n_cmp++; if (rx.size() !== 5)       begin n_bad++; $display("FAIL ws_rx_count: got %0d want 5", rx.size()); end
    for (int i = 0; i < 5; i++) begin
      exp_cti = (i == 4) ? 3'b111 : 3'b010;
      n_cmp++; if (beat_cti[i] !== exp_cti) begin n_bad++; $display("FAIL ws_cti[%0d]: got %b want %b", i, beat_cti[i], exp_cti); end
      n_cmp++; if (rx[i] !== (32'h1100_0200 + 32'(4 * i))) begin n_bad++; $display("FAIL ws_data[%0d]: got %h want %h", i, rx[i], 32'h1100_0200 + 32'(4 * i)); end
    end
    wait_n = 0;
  endtask

  task automatic test_zero_and_ignored();
    clear_mon();
    dat_base = 32'h3300_0000; pix_ready = 1'b1;
    kick(32'h300, 16'd0);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy: got %b want 1", busy); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_off: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_off: got %b want 0", busy); end
    repeat (5) @(posedge clk); #1;
    n_cmp++; if (burst_cnt !== 0) begin n_bad++; $display("FAIL zero_no_cycle: got %0d bursts want 0", burst_cnt); end
    n_cmp++; if (done_cnt !== 1)  begin n_bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    clear_mon();
    kick(32'h400, 16'd3);
    start = 1'b1; base_adr = 32'h800; nb_words = 16'd10;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_idle(300, "ign");
    n_cmp++; if (beat_adr.size() !== 3) begin n_bad++; $display("FAIL ign_beats: got %0d want 3", beat_adr.size()); end
    n_cmp++; if (beat_adr[0] !== 32'h400) begin n_bad++; $display("FAIL ign_adr0: got %h want 400", beat_adr[0]); end
    n_cmp++; if (beat_adr[2] !== 32'h408) begin n_bad++; $display("FAIL ign_adr2: got %h want 408", beat_adr[2]); end
    n_cmp++; if (rx.size() !== 3)       begin n_bad++; $display("FAIL ign_rx_count: got %0d want 3", rx.size()); end
    n_cmp++; if (done_cnt !== 1)        begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    bit found;
    clear_mon();
    dat_base = 32'h4400_0000; pix_ready = 1'b0;
    kick(32'h500, 16'd8);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wb_cyc && wb_adr == 32'h508) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rst_beat3_reached: got %b want 1", found); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (wb_cyc !== 1'b0)    begin n_bad++; $display("FAIL rst_cyc: got %b want 0", wb_cyc); end
    n_cmp++; if (wb_stb !== 1'b0)    begin n_bad++; $display("FAIL rst_stb: got %b want 0", wb_stb); end
    n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (pix_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", pix_valid); end
    rst_n = 1'b1;
    clear_mon();
    dat_base = 32'h2200_0000; pix_ready = 1'b1;
    kick(32'h600, 16'd4);
    wait_idle(300, "rst_restart");
    n_cmp++; if (beat_adr.size() !== 4) begin n_bad++; $display("FAIL rst_restart_beats: got %0d want 4", beat_adr.size()); end
    n_cmp++; if (rx.size() !== 4)       begin n_bad++; $display("FAIL rst_restart_rx: got %0d want 4", rx.size()); end
    n_cmp++; if (done_cnt !== 1)        begin n_bad++; $display("FAIL rst_restart_done: got %0d want 1", done_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rx[i] !== (32'h2200_0600 + 32'(4 * i))) begin n_bad++; $display("FAIL rst_restart_data[%0d]: got %h want %h", i, rx[i], 32'h2200_0600 + 32'(4 * i)); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; base_adr = '0; nb_words = '0; pix_ready = 1'b0;
    wb_ack = 1'b0; wb_dat_sm = '0;
    test_reset();
    test_single_word();
    test_multi_burst();
    test_backpressure();
    test_wait_states();
    test_zero_and_ignored();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
